// File: rtl/vpu_test_pkg.sv
// Shared types, constants, operand generators and golden model for the VPU self-test.
// The golden model is written directly from the op definitions and does not share code
// with the ALU datapath, so a datapath bug cannot hide behind a matching model bug.
package vpu_test_pkg;

   localparam int NUM_LANES   = 4;
   localparam int LANE_W      = 8;
   localparam int VEC_W       = NUM_LANES * LANE_W;
   localparam int NUM_TESTS   = 16;
   localparam int START_DELAY = 16;
   localparam int RESP_TMO    = 64;

   typedef enum logic [2:0] {
      OP_ADD  = 3'd0,
      OP_SUB  = 3'd1,
      OP_AND  = 3'd2,
      OP_OR   = 3'd3,
      OP_XOR  = 3'd4,
      OP_MINU = 3'd5,
      OP_MAXU = 3'd6,
      OP_SLL  = 3'd7
   } vpu_op_e;

   typedef logic [LANE_W-1:0]                 lane_t;
   typedef logic [NUM_LANES-1:0][LANE_W-1:0]  vec_t;

   function automatic vpu_op_e op_of(int i);
      return vpu_op_e'(3'(i));
   endfunction

   // lane k: A = 0x10*k + i + 3 (mod 256)
   function automatic vec_t gen_a(int i);
      vec_t v;
      for (int k = 0; k < NUM_LANES; k++) v[k] = lane_t'(16 * k + i + 3);
      return v;
   endfunction

   // lane k: B = 0x25 + 0x07*k + i (mod 256)
   function automatic vec_t gen_b(int i);
      vec_t v;
      for (int k = 0; k < NUM_LANES; k++) v[k] = lane_t'(37 + 7 * k + i);
      return v;
   endfunction

   function automatic vec_t vpu_golden(vpu_op_e op, vec_t a, vec_t b);
      vec_t r;
      r = '0;
      for (int k = 0; k < NUM_LANES; k++) begin
         case (op)
            OP_ADD:  r[k] = a[k] + b[k];
            OP_SUB:  r[k] = a[k] - b[k];
            OP_AND:  r[k] = a[k] & b[k];
            OP_OR:   r[k] = a[k] | b[k];
            OP_XOR:  r[k] = a[k] ^ b[k];
            OP_MINU: r[k] = (a[k] <= b[k]) ? a[k] : b[k];
            OP_MAXU: r[k] = (a[k] >= b[k]) ? a[k] : b[k];
            OP_SLL:  r[k] = a[k] << b[k][2:0];
            default: r[k] = '0;
         endcase
      end
      return r;
   endfunction

endpackage

// File: rtl/fpga_vpu_self_test_if.sv
// Sequencer <-> SIMD ALU request/result channel.
interface fpga_vpu_self_test_if;
   import vpu_test_pkg::*;

   logic    in_valid;
   logic    in_ready;
   vpu_op_e op;
   vec_t    a;
   vec_t    b;
   logic    out_valid;
   vec_t    res;

   modport master (output in_valid, op, a, b, input in_ready, out_valid, res);
   modport slave  (input in_valid, op, a, b, output in_ready, out_valid, res);
endinterface

// File: rtl/vpu_lane_alu.sv
// 2-stage SIMD ALU: stage 1 registers the accepted request, stage 2 registers the
// lane results. out_valid pulses for one cycle, two cycles after the accept; the
// ALU refuses new work while a request is in flight.
module vpu_lane_alu
   import vpu_test_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   fpga_vpu_self_test_if.slave bus
);

   logic    v1, v2;
   vpu_op_e op_q;
   vec_t    a_q, b_q, res_q, res_d;
   logic    accept;

   assign bus.in_ready  = ~(v1 | v2);
   assign accept        = bus.in_valid & bus.in_ready;
   assign bus.out_valid = v2;
   assign bus.res       = res_q;

   // pipeline valids, operand capture and result register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v1    <= 1'b0;
         v2    <= 1'b0;
         op_q  <= OP_ADD;
         a_q   <= '0;
         b_q   <= '0;
         res_q <= '0;
      end else begin
         v1 <= accept;
         v2 <= v1;
         if (accept) begin
            op_q <= bus.op;
            a_q  <= bus.a;
            b_q  <= bus.b;
         end
         if (v1) res_q <= res_d;
      end
   end

   for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
      lane_t la, lb, diff, sh1, sh2, sh4, r;
      logic  lt;

      assign la   = a_q[g];
      assign lb   = b_q[g];
      assign diff = la + ~lb + lane_t'(1);
      assign lt   = (la < lb);
      // barrel shifter on B[2:0]
      assign sh1  = lb[0] ? {la[LANE_W-2:0], 1'b0}    : la;
      assign sh2  = lb[1] ? {sh1[LANE_W-3:0], 2'b00}  : sh1;
      assign sh4  = lb[2] ? {sh2[LANE_W-5:0], 4'h0}   : sh2;

      // per-lane op select
      always_comb begin
         r = '0;
         case (op_q)
            OP_ADD:  r = la + lb;
            OP_SUB:  r = diff;
            OP_AND:  r = la & lb;
            OP_OR:   r = la | lb;
            OP_XOR:  r = la ^ lb;
            OP_MINU: r = lt ? la : lb;
            OP_MAXU: r = lt ? lb : la;
            OP_SLL:  r = sh4;
            default: r = '0;
         endcase
      end

      assign res_d[g] = r;
   end

endmodule

// File: rtl/fpga_vpu_self_test_top.sv
// Board self-test top: reset synchroniser, test sequencer, result comparator, LEDs.
// led = {RUN, BUSY, FAIL, PASS}.
// Build option VPU_ERR_INJECT_EN: corrupts the expectation of test 5 (lane 0 bit 0)
// so a healthy ALU must end in FAIL, proving the checker can trip.
module fpga_vpu_self_test_top
   import vpu_test_pkg::*;
(
   input  logic       clk_100mhz,
   input  logic       btn0,
   output logic [3:0] led
);

   localparam int CNT_W = 7;
   localparam int IDX_W = $clog2(NUM_TESTS);

   typedef enum logic [2:0] {
      S_DELAY, S_ISSUE, S_WAIT, S_CHECK, S_PASS, S_FAIL
   } state_e;

   logic [1:0]       rst_sync;
   logic             rst_n;
   state_e           state, state_d;
   logic [CNT_W-1:0] cnt, cnt_d;
   logic [IDX_W-1:0] idx, idx_d;
   vec_t             res_cap, exp_vec;
   logic             issue, busy;

   fpga_vpu_self_test_if alu_bus ();

   vpu_lane_alu u_alu (
      .clk   (clk_100mhz),
      .rst_n (rst_n),
      .bus   (alu_bus.slave)
   );

   // reset asserts immediately, releases two clocks later
   always_ff @(posedge clk_100mhz or negedge btn0) begin
      if (!btn0) rst_sync <= 2'b00;
      else       rst_sync <= {rst_sync[0], 1'b1};
   end
   assign rst_n = rst_sync[1];

   assign alu_bus.in_valid = issue;
   assign alu_bus.op       = op_of(int'(idx));
   assign alu_bus.a        = gen_a(int'(idx));
   assign alu_bus.b        = gen_b(int'(idx));

   // golden expectation for the test currently in flight
   always_comb begin
      exp_vec = vpu_golden(op_of(int'(idx)), gen_a(int'(idx)), gen_b(int'(idx)));
`ifdef VPU_ERR_INJECT_EN
      if (idx == IDX_W'(5)) exp_vec[0][0] = ~exp_vec[0][0];
`endif
   end

   // sequencer state, counters and captured result
   always_ff @(posedge clk_100mhz or negedge rst_n) begin
      if (!rst_n) begin
         state   <= S_DELAY;
         cnt     <= '0;
         idx     <= '0;
         res_cap <= '0;
      end else begin
         state <= state_d;
         cnt   <= cnt_d;
         idx   <= idx_d;
         if (state == S_WAIT && alu_bus.out_valid) res_cap <= alu_bus.res;
      end
   end

   // next-state: start delay, issue, wait with timeout, compare
   always_comb begin
      state_d = state;
      cnt_d   = cnt;
      idx_d   = idx;
      issue   = 1'b0;
      case (state)
         S_DELAY: begin
            if (cnt == CNT_W'(START_DELAY - 1)) begin
               state_d = S_ISSUE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt + CNT_W'(1);
            end
         end
         S_ISSUE: begin
            issue = 1'b1;
            if (alu_bus.in_ready) begin
               state_d = S_WAIT;
               cnt_d   = '0;
            end
         end
         S_WAIT: begin
            if (alu_bus.out_valid)                  state_d = S_CHECK;
            else if (cnt == CNT_W'(RESP_TMO - 1))  state_d = S_FAIL;
            else                                    cnt_d   = cnt + CNT_W'(1);
         end
         S_CHECK: begin
            if (res_cap != exp_vec)                 state_d = S_FAIL;
            else if (idx == IDX_W'(NUM_TESTS - 1))  state_d = S_PASS;
            else begin
               state_d = S_ISSUE;
               idx_d   = idx + IDX_W'(1);
            end
         end
         default: ;
      endcase
   end

   assign busy = (state == S_ISSUE) || (state == S_WAIT) || (state == S_CHECK);
   assign led  = {rst_n, busy, state == S_FAIL, state == S_PASS};

endmodule

// File: tb/tb_fpga_vpu_self_test_top.sv
// Randomized reset/abort bench for the VPU self-test top. The reference model predicts
// the LEDs from elapsed cycles since button release (2-cycle sync, start delay, 4 cycles
// per test) and recomputes every ALU result with plain integer arithmetic.
module tb_fpga_vpu_self_test_top;
   import vpu_test_pkg::*;

`ifdef VPU_ERR_INJECT_EN
   localparam int         LAST_TEST = 5;
   localparam logic [3:0] FINAL_LED = 4'b1010;
`else
   localparam int         LAST_TEST = NUM_TESTS - 1;
   localparam logic [3:0] FINAL_LED = 4'b1001;
`endif
   localparam int BUSY_EDGE = 2 + START_DELAY;
   localparam int DONE_EDGE = BUSY_EDGE + 4 * (LAST_TEST + 1);

   logic       clk = 1'b0;
   logic       btn0 = 1'b0;
   logic [3:0] led;
   int         errs = 0;
   int         checks = 0;

   fpga_vpu_self_test_top dut (
      .clk_100mhz (clk),
      .btn0       (btn0),
      .led        (led)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [3:0] model_led(int n);
      if (n < 2)         return 4'b0000;
      if (n < BUSY_EDGE) return 4'b1000;
      if (n < DONE_EDGE) return 4'b1100;
      return FINAL_LED;
   endfunction

   function automatic logic model_vld(int n);
      return (n >= BUSY_EDGE) && (n < DONE_EDGE) && ((n - BUSY_EDGE) % 4 == 2);
   endfunction

   function automatic logic [31:0] model_res(int t);
      logic [31:0] r;
      int a, b, x;
      r = '0;
      for (int k = 0; k < 4; k++) begin
         a = (16 * k + t + 3) % 256;
         b = (37 + 7 * k + t) % 256;
         case (t % 8)
            0: x = a + b;
            1: x = a - b + 256;
            2: x = a & b;
            3: x = a | b;
            4: x = a ^ b;
            5: x = (a < b) ? a : b;
            6: x = (a > b) ? a : b;
            default: x = a << (b % 8);
         endcase
         r[8*k +: 8] = 8'(x % 256);
      end
      return r;
   endfunction

   task automatic run(input int cycles, input int hold);
      btn0 = 1'b0;
      repeat (hold) begin
         @(negedge clk);
         chk("rst_led", 32'(led), 32'(4'b0000));
         chk("rst_vld", 32'(dut.alu_bus.out_valid), 32'(1'b0));
      end
      btn0 = 1'b1;
      for (int n = 1; n <= cycles; n++) begin
         @(negedge clk);
         chk("led", 32'(led), 32'(model_led(n)));
         chk("out_valid", 32'(dut.alu_bus.out_valid), 32'(model_vld(n)));
         if (model_vld(n)) chk("alu_res", dut.alu_bus.res, model_res((n - BUSY_EDGE) / 4));
      end
      #2 btn0 = 1'b0;
      #1 chk("abort_led", 32'(led), 32'(4'b0000));
   endtask

   initial begin
      run(0, 10);
      for (int r = 0; r < 4; r++)
         run($urandom_range(DONE_EDGE + 5, 3), $urandom_range(8, 1));
      run(DONE_EDGE + 40, 10);
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
